// File: rtl/swizzle_pkg.sv
// Shared types for the CRAM-to-DRAM tiled transposer: buffer and top-level state encodings
// and default geometry.
package swizzle_pkg;

  localparam int unsigned DEF_TILE   = 40;
  localparam int unsigned DEF_AWIDTH = 16;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_DRAINING
  } buf_state_e;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_RUN,
    TOP_DONE
  } top_state_e;

endpackage

// File: rtl/swizzle_tile_buffer.sv
// One TILE x TILE bit array: rows are written whole, columns are read whole.
// A clear zeroes the array so a partial tile drains with zero rows.
module swizzle_tile_buffer #(
  parameter int unsigned TILE  = 40,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_row,
  input  logic [TILE-1:0]  wr_data,
  input  logic [CNT_W-1:0] rd_col,
  output logic [TILE-1:0]  rd_data
);

  logic [TILE-1:0] cell_q [TILE];

  // Row write; clear wins so a drained buffer starts its next fill all-zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < TILE; r++) cell_q[r] <= '0;
    end else begin
      for (int r = 0; r < TILE; r++) begin
        if (clr) begin
          cell_q[r] <= '0;
        end else if (wr_en && (wr_row == CNT_W'(r))) begin
          cell_q[r] <= wr_data;
        end
      end
    end
  end

  // Column read: bit k of the result is row k at the selected column.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < TILE; j++) begin
      if (rd_col == CNT_W'(j)) begin
        for (int k = 0; k < TILE; k++) rd_data[k] = cell_q[k][j];
      end
    end
  end

endmodule

// File: rtl/swizzle_c2d_tiled.sv
// Ping-pong bit transposer between the CRAM read sequencer and the DRAM write port, with a
// single-register pass-through mode for DMA transfers.
module swizzle_c2d_tiled
  import swizzle_pkg::*;
#(
  parameter int unsigned TILE   = DEF_TILE,
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dma_mode,
  input  logic              start,
  input  logic [AWIDTH-1:0] mem_ctrl_addr_start,
  input  logic [TILE-1:0]   ram_data_in,
  input  logic              ram_data_valid,
  input  logic              ram_data_last,
  output logic              ram_data_ready,
  output logic [TILE-1:0]   mem_ctrl_data_out,
  output logic [AWIDTH-1:0] mem_ctrl_addr,
  output logic              mem_ctrl_we,
  input  logic              mem_ctrl_ready,
  output logic              done
);

  top_state_e        top_q, top_d;
  buf_state_e        buf_q [2];
  buf_state_e        buf_d [2];
  logic              fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d, drain_col_q, drain_col_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              dma_q, dma_d, last_seen_q, last_seen_d, dma_vld_q, dma_vld_d;
  logic [TILE-1:0]   dma_data_q, dma_data_d;
  logic [TILE-1:0]   rd_data [2];

  logic run, fill_open, drain_active, accept, beat, fill_done, drain_done, xfer_end;

  // Handshake and event decode shared by both modes.
  always_comb begin
    run          = (top_q == TOP_RUN);
    fill_open    = (buf_q[fill_sel_q] == BUF_EMPTY) || (buf_q[fill_sel_q] == BUF_FILLING);
    drain_active = (buf_q[drain_sel_q] == BUF_DRAINING);
    mem_ctrl_we  = dma_q ? dma_vld_q : drain_active;
    // Nothing more is taken once the final word is in.
    ram_data_ready = run && !last_seen_q &&
                     (dma_q ? (!dma_vld_q || mem_ctrl_ready) : fill_open);
    accept     = ram_data_valid && ram_data_ready;
    beat       = mem_ctrl_we && mem_ctrl_ready;
    fill_done  = accept && !dma_q && ((fill_cnt_q == CNT_W'(TILE-1)) || ram_data_last);
    drain_done = beat && !dma_q && (drain_col_q == CNT_W'(TILE-1));
    // The final tile is the one draining while the other buffer has nothing left.
    xfer_end   = last_seen_q && beat &&
                 (dma_q || (drain_done && (buf_q[~drain_sel_q] == BUF_EMPTY)));
    mem_ctrl_addr = addr_q;
    done          = (top_q == TOP_DONE);
    if (dma_q) mem_ctrl_data_out = dma_vld_q ? dma_data_q : '0;
    else       mem_ctrl_data_out = drain_active ? rd_data[drain_sel_q] : '0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    swizzle_tile_buffer #(
      .TILE  (TILE),
      .CNT_W (CNT_W)
    ) u_buf (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (drain_done && (drain_sel_q == 1'(b))),
      .wr_en   (accept && !dma_q && (fill_sel_q == 1'(b))),
      .wr_row  (fill_cnt_q),
      .wr_data (ram_data_in),
      .rd_col  (drain_col_q),
      .rd_data (rd_data[b])
    );
  end

  // Buffer lifecycle, fill/drain pointers, address, DMA register and top FSM next state.
  always_comb begin
    for (int b = 0; b < 2; b++) buf_d[b] = buf_q[b];
    top_d       = top_q;
    fill_sel_d  = fill_sel_q;
    fill_cnt_d  = fill_cnt_q;
    drain_sel_d = drain_sel_q;
    drain_col_d = drain_col_q;
    addr_d      = addr_q;
    dma_d       = dma_q;
    last_seen_d = last_seen_q;
    dma_vld_d   = dma_vld_q;
    dma_data_d  = dma_data_q;

    if (accept && !dma_q) begin
      if (fill_done) begin
        buf_d[fill_sel_q] = BUF_FULL;
        fill_sel_d        = ~fill_sel_q;
        fill_cnt_d        = '0;
      end else begin
        buf_d[fill_sel_q] = BUF_FILLING;
        fill_cnt_d        = fill_cnt_q + 1'b1;
      end
    end

    if (buf_q[drain_sel_q] == BUF_FULL) buf_d[drain_sel_q] = BUF_DRAINING;

    if (beat && !dma_q) begin
      if (drain_done) begin
        buf_d[drain_sel_q] = BUF_EMPTY;
        drain_sel_d        = ~drain_sel_q;
        drain_col_d        = '0;
        // Hand straight over to the other buffer so back-to-back tiles have no gap.
        if ((buf_q[~drain_sel_q] == BUF_FULL) || fill_done) buf_d[~drain_sel_q] = BUF_DRAINING;
      end else begin
        drain_col_d = drain_col_q + 1'b1;
      end
    end

    if (accept && dma_q) begin
      dma_data_d = ram_data_in;
      dma_vld_d  = 1'b1;
    end else if (beat && dma_q) begin
      dma_vld_d = 1'b0;
    end

    if (accept && ram_data_last) last_seen_d = 1'b1;
    if (beat) addr_d = addr_q + 1'b1;

    unique case (top_q)
      TOP_IDLE: begin
        dma_d = dma_mode;
        if (start) begin
          top_d       = TOP_RUN;
          addr_d      = mem_ctrl_addr_start;
          last_seen_d = 1'b0;
        end
      end
      TOP_RUN:  if (xfer_end) top_d = TOP_DONE;
      TOP_DONE: top_d = TOP_IDLE;
      default:  top_d = TOP_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      top_q       <= TOP_IDLE;
      for (int b = 0; b < 2; b++) buf_q[b] <= BUF_EMPTY;
      fill_sel_q  <= 1'b0;
      fill_cnt_q  <= '0;
      drain_sel_q <= 1'b0;
      drain_col_q <= '0;
      addr_q      <= '0;
      dma_q       <= 1'b0;
      last_seen_q <= 1'b0;
      dma_vld_q   <= 1'b0;
      dma_data_q  <= '0;
    end else begin
      top_q       <= top_d;
      for (int b = 0; b < 2; b++) buf_q[b] <= buf_d[b];
      fill_sel_q  <= fill_sel_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_sel_q <= drain_sel_d;
      drain_col_q <= drain_col_d;
      addr_q      <= addr_d;
      dma_q       <= dma_d;
      last_seen_q <= last_seen_d;
      dma_vld_q   <= dma_vld_d;
      dma_data_q  <= dma_data_d;
    end
  end

endmodule
